cache_mem_bram_responder: RTL

//  Responder (memory end) of the cache memory interface: accepts cache line reads (AR) and writes (AW+W).

---
 rtl/cache_mem_bram_responder_pkg.sv | 64 ++++++
 rtl/cache_mem_line_store.sv | 39 +++
 rtl/cache_mem_bram_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_bram_responder_pkg.sv
// Shared types and constants for the cache memory interface and its on-chip BRAM responder.
// Beat geometry, AXI-style response codes, channel payload structs and FSM state encodings.
package cache_mem_bram_responder_pkg;

   localparam int CACHE_MEM_BEATS     = 4;
   localparam int CACHE_MEM_BEAT_W    = 64;
   localparam int CACHE_MEM_LINE_OFFS = 5;
   localparam int CACHE_MEM_LINE_W    = CACHE_MEM_BEATS * CACHE_MEM_BEAT_W;
   localparam int CACHE_MEM_ID_W      = 4;
   localparam int CACHE_MEM_ADDR_W    = 32;

   typedef enum logic [1:0] {
      AXI4_OKAY   = 2'b00,
      AXI4_EXOKAY = 2'b01,
      AXI4_SLVERR = 2'b10,
      AXI4_DECERR = 2'b11
   } axi4_resp_t;

   typedef struct packed {
      logic [CACHE_MEM_ID_W-1:0]   arid;
      logic [CACHE_MEM_ADDR_W-1:0] araddr;
   } cache_mem_if_ar_t;

   typedef struct packed {
      logic [CACHE_MEM_ID_W-1:0]   awid;
      logic [CACHE_MEM_ADDR_W-1:0] awaddr;
   } cache_mem_if_aw_t;

   typedef struct packed {
      logic [CACHE_MEM_BEAT_W-1:0] wdata;
      logic                        wlast;
   } cache_mem_if_w_t;

   typedef struct packed {
      logic [CACHE_MEM_ID_W-1:0]   rid;
      logic [CACHE_MEM_BEAT_W-1:0] rdata;
      axi4_resp_t                  rresp;
      logic                        rlast;
   } cache_mem_if_r_t;

   typedef struct packed {
      logic [CACHE_MEM_ID_W-1:0] bid;
      axi4_resp_t                bresp;
   } cache_mem_if_b_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_BEAT = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   // Any address bit above the line-index field means the line is not backed by the store.
   function automatic logic addr_out_of_range(input logic [CACHE_MEM_ADDR_W-1:0] addr,
                                              input int idx_w);
      return (addr >> (CACHE_MEM_LINE_OFFS + idx_w)) != '0;
   endfunction

endpackage

// File: rtl/cache_mem_line_store.sv
// Simple dual-port line store: one 64-bit beat write port, one full-line read port.
// Organised as one bank per beat so a whole line is fetched in a single read, read-first.
module cache_mem_line_store
   import cache_mem_bram_responder_pkg::*;
#(
   parameter  int MEM_LINES = 4096,
   parameter  int RD_LAT    = 1,
   localparam int IDX_W     = $clog2(MEM_LINES)
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [IDX_W-1:0]            wr_idx,
   input  logic [1:0]                  wr_beat,
   input  logic [CACHE_MEM_BEAT_W-1:0] wr_data,
   input  logic                        rd_en,
   input  logic [IDX_W-1:0]            rd_idx,
   output logic [CACHE_MEM_LINE_W-1:0] rd_line
);

   logic [CACHE_MEM_BEAT_W-1:0] bank [CACHE_MEM_BEATS][MEM_LINES];
   logic [CACHE_MEM_LINE_W-1:0] rd_pipe [RD_LAT];

   always_ff @(posedge clk) begin
      for (int b = 0; b < CACHE_MEM_BEATS; b++) begin
         if (wr_en && wr_beat == 2'(b)) begin
            bank[b][wr_idx] <= wr_data;
         end
         if (rd_en) begin
            rd_pipe[0][b*CACHE_MEM_BEAT_W +: CACHE_MEM_BEAT_W] <= bank[b][rd_idx];
         end
      end
      for (int s = 1; s < RD_LAT; s++) begin
         rd_pipe[s] <= rd_pipe[s-1];
      end
   end

   assign rd_line = rd_pipe[RD_LAT-1];

endmodule

// File: rtl/cache_mem_bram_responder.sv
// Memory-end responder of the cache memory interface, serviced from an on-chip line store.
// One outstanding read and one outstanding write, each handled by its own FSM.
//
//   state  | meaning
//   R_IDLE | arready high, waiting for a read request; line fetch issued on accept
//   R_WAIT | line store read in flight, RD_LAT cycles, then line captured in hold register
//   R_BEAT | presenting beats 0..3 from the hold register
//   W_IDLE | awready high, W held off until a write request is accepted
//   W_DATA | wready high, exactly four beats written to consecutive words of the line
//   W_RESP | bvalid high until bready
module cache_mem_bram_responder
   import cache_mem_bram_responder_pkg::*;
#(
   parameter int MEM_LINES = 4096,
   parameter int RD_LAT    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_if_arvalid,
   output logic             req_if_arready,
   input  cache_mem_if_ar_t req_if_ar,
   input  logic             req_if_awvalid,
   output logic             req_if_awready,
   input  cache_mem_if_aw_t req_if_aw,
   input  logic             req_if_wvalid,
   output logic             req_if_wready,
   input  cache_mem_if_w_t  req_if_w,
   output logic             rsp_if_rvalid,
   input  logic             rsp_if_rready,
   output cache_mem_if_r_t  rsp_if_r,
   output logic             rsp_if_bvalid,
   input  logic             rsp_if_bready,
   output cache_mem_if_b_t  rsp_if_b
);

   localparam int         IDX_W     = $clog2(MEM_LINES);
   localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

   rd_state_t r_state, r_next;
   wr_state_t w_state, w_next;

   logic                        ar_take, r_take, aw_take, w_take;
   logic                        ar_err;
   logic                        rd_en;
   logic [IDX_W-1:0]            rd_idx;
   logic [CACHE_MEM_LINE_W-1:0] rd_line;
   logic [1:0]                  r_cnt;
   logic [2:0]                  r_wait_cnt;
   logic [CACHE_MEM_ID_W-1:0]   r_id;
   logic                        r_err;
   logic [CACHE_MEM_BEATS-1:0][CACHE_MEM_BEAT_W-1:0] r_hold;

   logic [1:0]                  w_cnt;
   logic [CACHE_MEM_ID_W-1:0]   w_id;
   logic [IDX_W-1:0]            w_idx;
   logic                        w_err, w_proto;
   logic                        wr_en;
   logic                        unused_addr_lsbs;

   assign ar_err = addr_out_of_range(req_if_ar.araddr, IDX_W);
   assign rd_idx = req_if_ar.araddr[CACHE_MEM_LINE_OFFS +: IDX_W];
   assign unused_addr_lsbs = ^{req_if_ar.araddr[CACHE_MEM_LINE_OFFS-1:0],
                               req_if_aw.awaddr[CACHE_MEM_LINE_OFFS-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
      end
   end

   // The fetch is issued straight from the AR payload so the line lands after RD_LAT cycles.
   always_comb begin
      r_next         = r_state;
      req_if_arready = 1'b0;
      rsp_if_rvalid  = 1'b0;
      ar_take        = 1'b0;
      r_take         = 1'b0;
      rd_en          = 1'b0;
      if (!rst) begin
         case (r_state)
            R_IDLE: begin
               req_if_arready = 1'b1;
               if (req_if_arvalid) begin
                  ar_take = 1'b1;
                  rd_en   = !ar_err;
                  r_next  = R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_wait_cnt == 3'd0) r_next = R_BEAT;
            end
            R_BEAT: begin
               rsp_if_rvalid = 1'b1;
               if (rsp_if_rready) begin
                  r_take = 1'b1;
                  if (r_cnt == 2'd3) r_next = R_IDLE;
               end
            end
            default: r_next = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_wait_cnt <= '0;
         r_id       <= '0;
         r_err      <= 1'b0;
      end else begin
         if (ar_take) begin
            r_id       <= req_if_ar.arid;
            r_err      <= ar_err;
            r_wait_cnt <= WAIT_LOAD;
            r_cnt      <= '0;
         end else if (r_state == R_WAIT && r_wait_cnt != 3'd0) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
         end
         if (r_take) r_cnt <= r_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == R_WAIT && r_wait_cnt == 3'd0) begin
         r_hold <= r_err ? '0 : rd_line;
      end
   end

   always_comb begin
      rsp_if_r = '0;
      if (rsp_if_rvalid) begin
         rsp_if_r.rid   = r_id;
         rsp_if_r.rdata = r_hold[r_cnt];
         rsp_if_r.rresp = r_err ? AXI4_SLVERR : AXI4_OKAY;
         rsp_if_r.rlast = (r_cnt == 2'd3);
      end
   end

   always_comb begin
      w_next         = w_state;
      req_if_awready = 1'b0;
      req_if_wready  = 1'b0;
      rsp_if_bvalid  = 1'b0;
      aw_take        = 1'b0;
      w_take         = 1'b0;
      if (!rst) begin
         case (w_state)
            W_IDLE: begin
               req_if_awready = 1'b1;
               if (req_if_awvalid) begin
                  aw_take = 1'b1;
                  w_next  = W_DATA;
               end
            end
            W_DATA: begin
               req_if_wready = 1'b1;
               if (req_if_wvalid) begin
                  w_take = 1'b1;
                  if (w_cnt == 2'd3) w_next = W_RESP;
               end
            end
            W_RESP: begin
               rsp_if_bvalid = 1'b1;
               if (rsp_if_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
         endcase
      end
   end

   assign wr_en = w_take && !w_err;

   // Beat count, not wlast, ends the burst; a misplaced wlast only poisons the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_cnt   <= '0;
         w_id    <= '0;
         w_idx   <= '0;
         w_err   <= 1'b0;
         w_proto <= 1'b0;
      end else begin
         if (aw_take) begin
            w_id    <= req_if_aw.awid;
            w_idx   <= req_if_aw.awaddr[CACHE_MEM_LINE_OFFS +: IDX_W];
            w_err   <= addr_out_of_range(req_if_aw.awaddr, IDX_W);
            w_proto <= 1'b0;
            w_cnt   <= '0;
         end
         if (w_take) begin
            w_cnt <= w_cnt + 2'd1;
            if (req_if_w.wlast != (w_cnt == 2'd3)) w_proto <= 1'b1;
         end
      end
   end

   always_comb begin
      rsp_if_b = '0;
      if (rsp_if_bvalid) begin
         rsp_if_b.bid   = w_id;
         rsp_if_b.bresp = (w_err || w_proto) ? AXI4_SLVERR : AXI4_OKAY;
      end
   end

   cache_mem_line_store #(
      .MEM_LINES (MEM_LINES),
      .RD_LAT    (RD_LAT)
   ) u_line_store (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (w_idx),
      .wr_beat (w_cnt),
      .wr_data (req_if_w.wdata),
      .rd_en   (rd_en),
      .rd_idx  (rd_idx),
      .rd_line (rd_line)
   );

endmodule
